// File: rtl/rx_deq_pkg.sv
// Package for the RX dequeue block.
// Holds the FIFO status-byte bit positions, the dequeue FSM state type and
// a helper that isolates the byte-modulus field of a status byte.
package rx_deq_pkg;

  // Bit positions inside the 8-bit FIFO head status byte.
  localparam int unsigned STAT_EOP = 7;
  localparam int unsigned STAT_SOP = 6;
  localparam int unsigned STAT_ERR = 5;

  typedef enum logic [1:0] {
    StIdle,
    StInPkt,
    StGap,
    StFlush
  } deq_state_e;

  // Keep only the low mod_w bits of the status byte (the byte modulus).
  function automatic logic [7:0] mod_field(input logic [7:0] status, input int unsigned mod_w);
    logic [7:0] mask;
    mask = 8'((32'd1 << mod_w) - 32'd1);
    return status & mask;
  endfunction

endpackage

// File: rtl/rx_deq_sat_cnt.sv
// Saturating statistics counter.
// Ports:
//   clk_156m25      core clock
//   reset_156m25_n  async active-low reset, clears the count
//   inc             add one this cycle (ignored once at all-ones)
//   clr             synchronous clear, wins over inc
//   cnt             current count
module rx_deq_sat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rx_dequeue_gen.sv
// RX dequeue: pops packet words from the show-ahead RX data FIFO and drives
// the registered client packet bus. Enforces an inter-packet gap, recovers from
// underflow / missing SOP / missing EOP by flushing to the next SOP, and keeps
// saturating packet, error and drop counters.
// Ports:
//   clk_156m25, reset_156m25_n        core clock, async active-low reset
//   rxdfifo_rdata/rstatus             FIFO head word and status (EOP/SOP/ERR/mod)
//   rxdfifo_rempty/ralmost_empty      FIFO level flags
//   pkt_rx_ren                        client read request
//   rxdfifo_ren                       FIFO pop, combinational
//   pkt_rx_data/val/sop/eop/err/mod   client packet bus, one cycle after the pop
//   pkt_rx_avail                      registered !rxdfifo_ralmost_empty
//   status_rxdfifo_udflow_tog         toggles once per underflow
//   stat_pkt_cnt/err_cnt/drop_cnt     saturating statistics
module rx_dequeue_gen
  import rx_deq_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MOD_W      = $clog2(DATA_W / 8),
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic [DATA_W-1:0] rxdfifo_rdata,
  input  logic [7:0]        rxdfifo_rstatus,
  input  logic              rxdfifo_rempty,
  input  logic              rxdfifo_ralmost_empty,
  input  logic              pkt_rx_ren,
  output logic              rxdfifo_ren,
  output logic [DATA_W-1:0] pkt_rx_data,
  output logic              pkt_rx_val,
  output logic              pkt_rx_sop,
  output logic              pkt_rx_eop,
  output logic              pkt_rx_err,
  output logic [MOD_W-1:0]  pkt_rx_mod,
  output logic              pkt_rx_avail,
  output logic              status_rxdfifo_udflow_tog,
  output logic [CNT_W-1:0]  stat_pkt_cnt,
  output logic [CNT_W-1:0]  stat_err_cnt,
  output logic [CNT_W-1:0]  stat_drop_cnt
);

  localparam logic [3:0] GapLoad = 4'(GAP_CYCLES);
  localparam bit         GapEn   = (GAP_CYCLES > 0);

  deq_state_e state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic       pkt_err_q, pkt_err_d;   // sticky error for the packet in progress

  logic             head_valid, head_sop, head_eop, head_err;
  logic [7:0]       head_mod_full;
  logic [MOD_W-1:0] head_mod;

  logic             emit_val, emit_sop, emit_eop, emit_err;
  logic [MOD_W-1:0] emit_mod;
  logic             udflow, drop;

  logic [DATA_W-1:0] data_q;
  logic              val_q, sop_q, eop_q, err_q, avail_q, udflow_tog_q;
  logic [MOD_W-1:0]  mod_q;

  assign head_valid    = !rxdfifo_rempty;
  assign head_sop      = rxdfifo_rstatus[STAT_SOP];
  assign head_eop      = rxdfifo_rstatus[STAT_EOP];
  assign head_err      = rxdfifo_rstatus[STAT_ERR];
  assign head_mod_full = mod_field(rxdfifo_rstatus, MOD_W);
  assign head_mod      = head_mod_full[MOD_W-1:0];

  // Status bits between the mod field and ERR are reserved.
  logic unused_status;
  assign unused_status = ^{head_mod_full, rxdfifo_rstatus};

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    pkt_err_d   = pkt_err_q;
    rxdfifo_ren = 1'b0;
    emit_val    = 1'b0;
    emit_sop    = 1'b0;
    emit_eop    = 1'b0;
    emit_err    = 1'b0;
    emit_mod    = '0;
    udflow      = 1'b0;
    drop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pkt_rx_ren && head_valid) begin
          if (head_sop) begin
            rxdfifo_ren = 1'b1;
            emit_val    = 1'b1;
            emit_sop    = 1'b1;
            emit_err    = head_err;
            pkt_err_d   = head_err;
            if (head_eop) begin
              emit_eop  = 1'b1;
              emit_mod  = head_mod;
              pkt_err_d = 1'b0;
              if (GapEn) begin
                state_d = StGap;
                gap_d   = GapLoad;
              end else begin
                state_d = StIdle;
              end
            end else begin
              state_d = StInPkt;
            end
          end else begin
            // Stray mid-packet word at the head: resynchronise on next SOP.
            state_d = StFlush;
          end
        end
      end

      StInPkt: begin
        if (pkt_rx_ren) begin
          if (!head_valid) begin
            // Underflow: close the packet with an errored EOP, data held.
            emit_val  = 1'b1;
            emit_eop  = 1'b1;
            emit_err  = 1'b1;
            udflow    = 1'b1;
            pkt_err_d = 1'b0;
            state_d   = StFlush;
          end else if (head_sop) begin
            // Next packet started before our EOP: synthesise an errored EOP
            // and leave the SOP word in the FIFO for IDLE to pick up.
            emit_val  = 1'b1;
            emit_eop  = 1'b1;
            emit_err  = 1'b1;
            pkt_err_d = 1'b0;
            state_d   = StIdle;
          end else begin
            rxdfifo_ren = 1'b1;
            emit_val    = 1'b1;
            emit_err    = pkt_err_q | head_err;
            pkt_err_d   = pkt_err_q | head_err;
            if (head_eop) begin
              emit_eop  = 1'b1;
              emit_mod  = head_mod;
              pkt_err_d = 1'b0;
              if (GapEn) begin
                state_d = StGap;
                gap_d   = GapLoad;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
      end

      StGap: begin
        // Only cycles the client actually asks for count toward the gap.
        if (pkt_rx_ren) begin
          if (gap_q <= 4'd1) begin
            gap_d   = 4'd0;
            state_d = StIdle;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
      end

      StFlush: begin
        if (head_valid) begin
          if (head_sop) begin
            state_d = StIdle;
          end else begin
            rxdfifo_ren = 1'b1;
            drop        = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q      <= StIdle;
      gap_q        <= 4'd0;
      pkt_err_q    <= 1'b0;
      data_q       <= '0;
      val_q        <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      err_q        <= 1'b0;
      mod_q        <= '0;
      avail_q      <= 1'b0;
      udflow_tog_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      pkt_err_q    <= pkt_err_d;
      val_q        <= emit_val;
      sop_q        <= emit_sop;
      eop_q        <= emit_eop;
      err_q        <= emit_err;
      mod_q        <= emit_mod;
      avail_q      <= !rxdfifo_ralmost_empty;
      udflow_tog_q <= udflow_tog_q ^ udflow;
      if (rxdfifo_ren) begin
        data_q <= rxdfifo_rdata;
      end
    end
  end

  assign pkt_rx_data               = data_q;
  assign pkt_rx_val                = val_q;
  assign pkt_rx_sop                = sop_q;
  assign pkt_rx_eop                = eop_q;
  assign pkt_rx_err                = err_q;
  assign pkt_rx_mod                = mod_q;
  assign pkt_rx_avail              = avail_q;
  assign status_rxdfifo_udflow_tog = udflow_tog_q;

  // Counters advance on the same edge that registers the EOP/drop.
  rx_deq_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_pkt_cnt (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .inc            (emit_eop),
    .clr            (1'b0),
    .cnt            (stat_pkt_cnt)
  );

  rx_deq_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .inc            (emit_eop & emit_err),
    .clr            (1'b0),
    .cnt            (stat_err_cnt)
  );

  rx_deq_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .inc            (drop),
    .clr            (1'b0),
    .cnt            (stat_drop_cnt)
  );

endmodule
